// File: rtl/instr_mem_loader.sv
// instr_mem_loader
//   Instruction memory with a byte-serial loader. A host streams bytes over a
//   valid/ready port. Bytes are packed little-endian into DATA_W-bit words,
//   and each word is written at an auto-incrementing address that starts from
//   a programmable base. The fetch stage reads the memory through a registered
//   port with one cycle of latency. Fetches are only served while the loader
//   is idle.
//
//   Optional build macro: IMEM_PARITY_EN
//     When it is defined, each word is stored with an even-parity bit, and a
//     fetch flags fetch_perr_o when the stored bit and the word disagree.
//     When it is not defined, fetch_perr_o is tied low.
//
//   Parameters
//     DATA_W  word width, must be a multiple of 8
//     ADDR_W  word address width, DEPTH = 2**ADDR_W
//
//   Ports
//     clk_i          clock, rising edge
//     rst_ni         asynchronous active-low reset
//     load_start_i   one-cycle load request (sampled in IDLE only)
//     load_base_i    first word address of the load
//     load_len_i     number of words to load, 0..DEPTH
//     load_valid_i   load_byte_i is valid
//     load_byte_i    load data byte
//     load_ready_o   a byte is accepted this cycle (high in LOAD)
//     load_done_o    one-cycle pulse when a load completes
//     busy_o         high while in LOAD
//     fetch_en_i     fetch request
//     fetch_addr_i   fetch word address
//     fetch_data_o   fetched word (holds its value when no fetch is served)
//     fetch_valid_o  fetch_data_o holds a fresh word
//     fetch_perr_o   parity error on the fetched word
module instr_mem_loader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_start_i,
  input  logic [ADDR_W-1:0] load_base_i,
  input  logic [ADDR_W:0]   load_len_i,
  input  logic              load_valid_i,
  input  logic [7:0]        load_byte_i,
  output logic              load_ready_o,
  output logic              load_done_o,
  output logic              busy_o,
  input  logic              fetch_en_i,
  input  logic [ADDR_W-1:0] fetch_addr_i,
  output logic [DATA_W-1:0] fetch_data_o,
  output logic              fetch_valid_o,
  output logic              fetch_perr_o
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   fetch_data_q;
  logic                fetch_valid_q;

  logic                wr_en;
  logic                fetch_go;

  logic [DATA_W-1:0]   mem [DEPTH];

  // Next-state logic. The byte being accepted is merged into word_d, so on
  // the last byte of a word word_d is exactly the word that gets written.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    count_d  = count_q;
    idx_d    = idx_q;
    word_d   = word_q;
    done_d   = 1'b0;
    wr_en    = 1'b0;
    fetch_go = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (load_start_i) begin
          addr_d  = load_base_i;
          count_d = load_len_i;
          idx_d   = '0;
          // A zero-length load never enters LOAD; it only reports completion.
          if (load_len_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end else begin
          // A load request takes priority over a fetch in the same cycle.
          fetch_go = fetch_en_i;
        end
      end
      LOAD: begin
        if (load_valid_i) begin
          word_d[{idx_q, 3'b000} +: 8] = load_byte_i;
          if (idx_q == LAST_IDX) begin
            wr_en   = 1'b1;
            addr_d  = addr_q + ADDR_W'(1);
            count_d = count_q - (ADDR_W + 1)'(1);
            idx_d   = '0;
            if (count_q == (ADDR_W + 1)'(1)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      count_q <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      done_q  <= done_d;
    end
  end

  // Storage has no reset so that words written before a reset survive it.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[addr_q] <= word_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_data_q  <= '0;
      fetch_valid_q <= 1'b0;
    end else begin
      fetch_valid_q <= fetch_go;
      if (fetch_go) begin
        fetch_data_q <= mem[fetch_addr_i];
      end
    end
  end

`ifdef IMEM_PARITY_EN
  // Even parity: the word and its stored bit together always have an even
  // number of ones, so their combined XOR is nonzero only on corruption.
  logic par_mem [DEPTH];
  logic fetch_perr_q;

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      par_mem[addr_q] <= ^word_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_perr_q <= 1'b0;
    end else begin
      fetch_perr_q <= fetch_go & ((^mem[fetch_addr_i]) ^ par_mem[fetch_addr_i]);
    end
  end

  assign fetch_perr_o = fetch_perr_q;
`else
  assign fetch_perr_o = 1'b0;
`endif

  assign load_ready_o  = (state_q == LOAD);
  assign busy_o        = (state_q == LOAD);
  assign load_done_o   = done_q;
  assign fetch_data_o  = fetch_data_q;
  assign fetch_valid_o = fetch_valid_q;

endmodule
